min_hour_counter: RTL

Timekeeping stage directly downstream of the seconds counter. Consumes that counter's one_min indication and maintains minutes (0-59) and hours (0-23). Provides a user time-set state machine with hour/minute adjust, a one-day carry pulse, and a one-cycle seconds-clear strobe for the upstream seconds counter. Outputs feed the display/BCD stage.

---
 rtl/min_hour_counter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/min_hour_counter.sv
// min_hour_counter: minutes/hours timekeeping stage fed by the seconds counter.
// Counts minutes (0-59) and hours (0-23) on rising edges of one_min, provides a
// RUN -> SET_HOUR -> SET_MIN user time-set FSM with increment button, a one-day
// carry pulse, a blink enable for the field being set, and a one-cycle
// active-low seconds-clear strobe when leaving SET_MIN.
// Optional build macro: TWELVE_HOUR_EN (12-hour display encoding plus pm flag).
module min_hour_counter #(
  parameter int BLINK_DIV = 25000000,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_min,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic       pm,
  output logic [1:0] set_state,
  output logic       blink,
  output logic       one_day,
  output logic       sec_clr_n
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [4:0] INIT_HOUR_V = 5'(INIT_HOUR);
  localparam logic [5:0] INIT_MIN_V  = 6'(INIT_MIN);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  // Edge-detect pipeline: one sample stage plus the previous sample
  logic one_min_cur_q, one_min_prev_q;
  logic mode_cur_q, mode_prev_q;
  logic inc_cur_q, inc_prev_q;

  logic min_ev, mode_ev, inc_ev;

  state_t           state_q, state_d;
  logic [5:0]       minute_q, minute_d;
  logic [4:0]       hour_q, hour_d;
  logic             one_day_q, one_day_d;
  logic             sec_clr_n_q, sec_clr_n_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  assign min_ev  = one_min_cur_q & ~one_min_prev_q;
  assign mode_ev = mode_cur_q & ~mode_prev_q;
  assign inc_ev  = inc_cur_q & ~inc_prev_q;

  // Sample the three inputs and keep the previous sample for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      one_min_cur_q  <= 1'b0;
      one_min_prev_q <= 1'b0;
      mode_cur_q     <= 1'b0;
      mode_prev_q    <= 1'b0;
      inc_cur_q      <= 1'b0;
      inc_prev_q     <= 1'b0;
    end else begin
      one_min_cur_q  <= one_min;
      one_min_prev_q <= one_min_cur_q;
      mode_cur_q     <= mode_btn;
      mode_prev_q    <= mode_cur_q;
      inc_cur_q      <= inc_btn;
      inc_prev_q     <= inc_cur_q;
    end
  end

  // Next-state logic: FSM transitions, time arithmetic, strobes and blink timing
  always_comb begin
    state_d     = state_q;
    minute_d    = minute_q;
    hour_d      = hour_q;
    one_day_d   = 1'b0;
    sec_clr_n_d = 1'b1;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    case (state_q)
      ST_RUN: begin
        // A mode edge does not block a coincident minute tick
        if (min_ev) begin
          if (minute_q == 6'd59) begin
            minute_d = 6'd0;
            if (hour_q == 5'd23) begin
              hour_d    = 5'd0;
              one_day_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            minute_d = minute_q + 6'd1;
          end
        end
        if (mode_ev) begin
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        // Mode wins over a coincident inc; one_min ticks are dropped here
        if (mode_ev) begin
          state_d = ST_SET_MIN;
        end else if (inc_ev) begin
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
      end
      ST_SET_MIN: begin
        if (mode_ev) begin
          state_d     = ST_RUN;
          sec_clr_n_d = 1'b0;
        end else if (inc_ev) begin
          minute_d = (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Blink phase restarts on every state change and idles in RUN
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // State and output registers; reset forces RUN with INIT time and idle strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      minute_q    <= INIT_MIN_V;
      hour_q      <= INIT_HOUR_V;
      one_day_q   <= 1'b0;
      sec_clr_n_q <= 1'b1;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      minute_q    <= minute_d;
      hour_q      <= hour_d;
      one_day_q   <= one_day_d;
      sec_clr_n_q <= sec_clr_n_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

`ifdef TWELVE_HOUR_EN
  logic [4:0] hour_disp_q;
  logic       pm_q;

  // Map the 0-23 internal hour onto the 1-12 display range
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0) begin
      return 5'd12;
    end else if (h > 5'd12) begin
      return h - 5'd12;
    end else begin
      return h;
    end
  endfunction

  // Register the 12-hour view from the next internal hour so it lines up with minute
  always_ff @(posedge clk) begin
    if (!reset) begin
      hour_disp_q <= to_12h(INIT_HOUR_V);
      pm_q        <= (INIT_HOUR_V >= 5'd12);
    end else begin
      hour_disp_q <= to_12h(hour_d);
      pm_q        <= (hour_d >= 5'd12);
    end
  end

  assign hour = hour_disp_q;
  assign pm   = pm_q;
`else
  assign hour = hour_q;
  assign pm   = 1'b0;
`endif

  assign minute    = minute_q;
  assign set_state = state_q;
  assign blink     = blink_q;
  assign one_day   = one_day_q;
  assign sec_clr_n = sec_clr_n_q;

endmodule
